// File: rtl/pipe_hazard_unit_if.sv
// ID-stage <-> hazard unit bundle: ID instruction decode in, stall/forward/busy out.
interface pipe_hazard_if #(
    parameter int unsigned RW    = 5,
    parameter int unsigned DEPTH = 3
);
    localparam int unsigned FW = $clog2(DEPTH + 1);

    logic          id_valid;
    logic          id_wreg;
    logic          id_m2reg;
    logic          id_mdu;
    logic [RW-1:0] id_rn;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic          flush;
    logic          stall;
    logic [FW-1:0] fwd_a;
    logic [FW-1:0] fwd_b;
    logic          mdu_busy;
    logic [31:0]   stall_count;

    // ID stage side
    modport master (
        output id_valid, id_wreg, id_m2reg, id_mdu, id_rn, id_rs, id_rt,
               id_use_rs, id_use_rt, flush,
        input  stall, fwd_a, fwd_b, mdu_busy, stall_count
    );

    // Hazard unit side
    modport slave (
        input  id_valid, id_wreg, id_m2reg, id_mdu, id_rn, id_rs, id_rt,
               id_use_rs, id_use_rt, flush,
        output stall, fwd_a, fwd_b, mdu_busy, stall_count
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Hazard / forwarding / multi-cycle stall controller tracking DEPTH post-ID stages.
module pipe_hazard_unit #(
    parameter int unsigned RW      = 5,
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned MUL_LAT = 4
) (
    input  logic          Clock,
    input  logic          Resetn,
    pipe_hazard_if.slave  bus
);
    localparam int unsigned FW = $clog2(DEPTH + 1);
    localparam int unsigned CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LAT - 1);

    typedef struct packed {
        logic          v;
        logic [RW-1:0] rn;
        logic          ld;
    } slot_t;

    // Index 0 is EXE (stage 1), index DEPTH-1 is the oldest tracked stage.
    slot_t         slot     [DEPTH];
    slot_t         slot_nxt [DEPTH];
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [31:0]   count;
    logic [31:0]   count_nxt;

    logic          busy_c;
    logic          load_use_c;
    logic          stall_c;
    logic          issue_c;
    logic [FW-1:0] fwd_a_c;
    logic [FW-1:0] fwd_b_c;

    // Hazard detection: MDU window dominates, flush cancels a load-use stall.
    always_comb begin
        busy_c     = (cnt != '0);
        load_use_c = bus.id_valid & slot[0].v & slot[0].ld &
                     ((bus.id_use_rs & (bus.id_rs == slot[0].rn)) |
                      (bus.id_use_rt & (bus.id_rt == slot[0].rn)));
        stall_c    = busy_c | (load_use_c & ~bus.flush);
        issue_c    = bus.id_valid & ~stall_c & ~bus.flush;
    end

    // Forward select: scan oldest to youngest so the nearest match overwrites.
    always_comb begin
        fwd_a_c = '0;
        fwd_b_c = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (slot[k].v && bus.id_use_rs && (bus.id_rs != '0) && (slot[k].rn == bus.id_rs)) begin
                fwd_a_c = FW'(k + 1);
            end
            if (slot[k].v && bus.id_use_rt && (bus.id_rt != '0) && (slot[k].rn == bus.id_rt)) begin
                fwd_b_c = FW'(k + 1);
            end
        end
    end

    // Next tracking state: normal advance, or hold EXE and bubble behind it during MDU.
    always_comb begin
        for (int k = 0; k < int'(DEPTH); k++) begin
            slot_nxt[k] = slot[k];
        end
        cnt_nxt   = cnt;
        count_nxt = count;

        if (stall_c && (count != 32'hFFFF_FFFF)) begin
            count_nxt = count + 32'd1;
        end

        if (busy_c) begin
            for (int k = int'(DEPTH) - 1; k >= 2; k--) begin
                slot_nxt[k] = slot[k-1];
            end
            slot_nxt[1] = '0;
            cnt_nxt     = cnt - CW'(1);
        end else begin
            for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
                slot_nxt[k] = slot[k-1];
            end
            if (issue_c) begin
                slot_nxt[0].v  = bus.id_wreg & (bus.id_rn != '0);
                slot_nxt[0].rn = bus.id_rn;
                slot_nxt[0].ld = bus.id_m2reg;
                if (bus.id_mdu && (MUL_LAT > 1)) begin
                    cnt_nxt = CNT_LOAD;
                end
            end else begin
                slot_nxt[0] = '0;
            end
        end
    end

    // State registers.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                slot[k] <= '0;
            end
            cnt   <= '0;
            count <= '0;
        end else begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                slot[k] <= slot_nxt[k];
            end
            cnt   <= cnt_nxt;
            count <= count_nxt;
        end
    end

    assign bus.stall       = stall_c;
    assign bus.fwd_a       = fwd_a_c;
    assign bus.fwd_b       = fwd_b_c;
    assign bus.mdu_busy    = busy_c;
    assign bus.stall_count = count;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Randomized + directed bench for pipe_hazard_unit against a queue-based pipeline model.
module tb_pipe_hazard_unit;
    localparam int unsigned RW      = 5;
    localparam int unsigned DEPTH   = 3;
    localparam int unsigned MUL_LAT = 4;

    logic Clock;
    logic Resetn;

    pipe_hazard_if #(.RW(RW), .DEPTH(DEPTH)) b1 ();
    pipe_hazard_if #(.RW(6),  .DEPTH(5))     b2 ();

    pipe_hazard_unit #(.RW(RW), .DEPTH(DEPTH), .MUL_LAT(MUL_LAT)) dut (
        .Clock(Clock), .Resetn(Resetn), .bus(b1)
    );
    pipe_hazard_unit #(.RW(6), .DEPTH(5), .MUL_LAT(2)) dut2 (
        .Clock(Clock), .Resetn(Resetn), .bus(b2)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit v;
        int rn;
        bit ld;
    } ent_t;

    ent_t        pipe[$];   // pipe[0] = EXE
    int          mcnt;
    bit [31:0]   mcount;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t bubble();
        ent_t e;
        e.v = 1'b0; e.rn = 0; e.ld = 1'b0;
        return e;
    endfunction

    task automatic model_reset();
        pipe.delete();
        for (int i = 0; i < int'(DEPTH); i++) pipe.push_back(bubble());
        mcnt   = 0;
        mcount = 0;
    endtask

    function automatic bit m_load_use();
        bit hit_rs, hit_rt;
        hit_rs = b1.id_use_rs && (int'(b1.id_rs) == pipe[0].rn);
        hit_rt = b1.id_use_rt && (int'(b1.id_rt) == pipe[0].rn);
        return b1.id_valid && pipe[0].v && pipe[0].ld && (hit_rs || hit_rt);
    endfunction

    function automatic bit m_stall();
        return (mcnt > 0) || (m_load_use() && !b1.flush);
    endfunction

    function automatic int m_fwd(input int src, input bit used);
        if (!used || src == 0) return 0;
        foreach (pipe[i]) if (pipe[i].v && pipe[i].rn == src) return i + 1;
        return 0;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit   st, issue;
        ent_t e;
        st    = m_stall();
        issue = b1.id_valid && !st && !b1.flush;
        if (st && mcount != 32'hFFFF_FFFF) mcount++;
        if (mcnt > 0) begin
            pipe.insert(1, bubble());
            void'(pipe.pop_back());
            mcnt--;
        end else begin
            e = bubble();
            if (issue) begin
                e.v  = b1.id_wreg && (b1.id_rn != 0);
                e.rn = int'(b1.id_rn);
                e.ld = b1.id_m2reg;
                if (b1.id_mdu && MUL_LAT > 1) mcnt = MUL_LAT - 1;
            end
            pipe.push_front(e);
            void'(pipe.pop_back());
        end
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic compare_all();
        bit st;
        st = m_stall();
        check("stall",       b1.stall,       st);
        check("mdu_busy",    b1.mdu_busy,    mcnt > 0);
        check("stall_count", b1.stall_count, mcount);
        if (!st) begin
            check("fwd_a", b1.fwd_a, m_fwd(int'(b1.id_rs), b1.id_use_rs));
            check("fwd_b", b1.fwd_b, m_fwd(int'(b1.id_rt), b1.id_use_rt));
        end
    endtask

    task automatic drive(input bit v, input bit w, input bit ld, input bit mdu,
                         input int rn, input int rs, input int rt,
                         input bit urs, input bit urt, input bit fl);
        b1.id_valid  = v;
        b1.id_wreg   = w;
        b1.id_m2reg  = ld;
        b1.id_mdu    = mdu;
        b1.id_rn     = RW'(rn);
        b1.id_rs     = RW'(rs);
        b1.id_rt     = RW'(rt);
        b1.id_use_rs = urs;
        b1.id_use_rt = urt;
        b1.flush     = fl;
        #1;
        compare_all();
    endtask

    task automatic drive2(input bit v, input bit w, input int rn, input int r);
        b2.id_valid  = v;
        b2.id_wreg   = w;
        b2.id_m2reg  = 1'b0;
        b2.id_mdu    = 1'b0;
        b2.id_rn     = 6'(rn);
        b2.id_rs     = 6'(r);
        b2.id_rt     = 6'(r);
        b2.id_use_rs = v;
        b2.id_use_rt = v;
        b2.flush     = 1'b0;
    endtask

    task automatic tick();
        model_step();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
    endtask

    bit [31:0] base;

    initial begin
        Resetn = 1'b0;
        drive2(0, 0, 0, 0);
        b1.id_valid = 0; b1.id_wreg = 0; b1.id_m2reg = 0; b1.id_mdu = 0;
        b1.id_rn = '0; b1.id_rs = '0; b1.id_rt = '0;
        b1.id_use_rs = 0; b1.id_use_rt = 0; b1.flush = 0;
        model_reset();
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;

        // Reset state
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_stall", b1.stall, 0);
        check("rst_busy",  b1.mdu_busy, 0);
        check("rst_fwd_a", b1.fwd_a, 0);
        check("rst_count", b1.stall_count, 0);
        tick();

        // ALU chain on r3, then the same with r0
        drive(1, 1, 0, 0, 3, 1, 2, 1, 1, 0); tick();
        for (int t = 1; t <= 4; t++) begin
            drive(1, 1, 0, 0, 10 + t, 3, 0, 1, 0, 0);
            check("chain_fwd_a", b1.fwd_a, (t <= 3) ? t : 0);
            tick();
        end
        idle(DEPTH);
        drive(1, 1, 0, 0, 0, 1, 2, 1, 1, 0); tick();
        for (int t = 1; t <= 4; t++) begin
            drive(1, 1, 0, 0, 10 + t, 0, 0, 1, 1, 0);
            check("r0_fwd_a", b1.fwd_a, 0);
            check("r0_fwd_b", b1.fwd_b, 0);
            tick();
        end
        idle(DEPTH);

        // Load-use: lw r5; add r6,r5,r1
        base = b1.stall_count;
        drive(1, 1, 1, 0, 5, 2, 0, 1, 0, 0); tick();
        drive(1, 1, 0, 0, 6, 5, 1, 1, 1, 0);
        check("lu_stall", b1.stall, 1);
        tick();
        drive(1, 1, 0, 0, 6, 5, 1, 1, 1, 0);
        check("lu_stall2", b1.stall, 0);
        check("lu_fwd_a", b1.fwd_a, 2);
        check("lu_fwd_b", b1.fwd_b, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("lu_count", b1.stall_count - base, 1);
        tick();
        idle(DEPTH);

        // MDU: mul r7; dependent sub held in ID
        base = b1.stall_count;
        drive(1, 1, 0, 1, 7, 1, 2, 1, 1, 0); tick();
        for (int t = 1; t <= 3; t++) begin
            drive(1, 1, 0, 0, 8, 7, 2, 1, 1, 0);
            check("mdu_stall", b1.stall, 1);
            check("mdu_busy",  b1.mdu_busy, 1);
            tick();
        end
        drive(1, 1, 0, 0, 8, 7, 2, 1, 1, 0);
        check("mdu_release", b1.stall, 0);
        check("mdu_fwd_a",   b1.fwd_a, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("mdu_count", b1.stall_count - base, 3);
        tick();
        idle(DEPTH);

        // Flush coincident with load-use
        base = b1.stall_count;
        drive(1, 1, 1, 0, 2, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 0, 9, 2, 0, 1, 0, 1);
        check("fl_stall", b1.stall, 0);
        tick();
        drive(1, 0, 0, 0, 0, 2, 0, 1, 0, 0);
        check("fl_stall2", b1.stall, 0);
        check("fl_fwd_a",  b1.fwd_a, 2);
        check("fl_count",  b1.stall_count - base, 0);
        tick();
        idle(DEPTH);

        // Nearest wins on both parameter sets
        drive2(1, 1, 40, 0);
        drive(1, 1, 0, 0, 4, 0, 0, 0, 0, 0); tick();
        drive2(1, 1, 40, 0);
        drive(1, 1, 0, 0, 4, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 4, 4, 1, 1, 0);
        check("near_fwd_a", b1.fwd_a, 1);
        check("near_fwd_b", b1.fwd_b, 1);
        for (int t = 1; t <= 5; t++) begin
            drive2(1, 0, 0, 40);
            #1;
            check("near5_fwd_a", b2.fwd_a, t);
            check("near5_fwd_b", b2.fwd_b, t);
            check("near5_stall", b2.stall, 0);
            tick();
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        drive2(0, 0, 0, 0);
        idle(5);

        // Reset in the middle of an MDU window
        drive(1, 1, 0, 1, 7, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 0, 8, 7, 0, 1, 0, 0);
        check("pre_rst_busy", b1.mdu_busy, 1);
        #2 Resetn = 1'b0;
        #1;
        check("arst_stall", b1.stall, 0);
        check("arst_busy",  b1.mdu_busy, 0);
        check("arst_fwd_a", b1.fwd_a, 0);
        check("arst_count", b1.stall_count, 0);
        model_reset();
        @(negedge Clock);
        Resetn = 1'b1;
        drive(1, 1, 0, 0, 9, 1, 2, 1, 1, 0);
        check("post_rst_stall", b1.stall, 0);
        tick();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                  $urandom_range(0, 15) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
